// File: rtl/dsp_addsub_arbiter_pkg.sv
// Shared encodings for the DSP add/subtract arbiter: FSM states, ADDSUB
// control values and a small pointer-wrap helper.
package dsp_addsub_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Increment v modulo n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return ((v + 1) >= n) ? 0 : (v + 1);
  endfunction

endpackage

// File: rtl/dsp_addsub_arbiter_rr_arbiter.sv
// Rotating-priority one-hot grant: first asserted request scanning upward
// from ptr, modulo NUM_REQ. Purely combinational.
module dsp_addsub_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [PTR_W-1:0]   grant_idx_c,
  output logic               grant_any_c
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    grant_any_c = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % NUM_REQ);
      if (!grant_any_c && req[cand]) begin
        grant_any_c   = 1'b1;
        grant_c[cand] = 1'b1;
        grant_idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/dsp_addsub_arbiter.sv
// Shares one combinational add/subtract DSP path between NUM_REQ requesters
// with round-robin arbitration and valid/ready on both sides.
module dsp_addsub_arbiter
  import dsp_addsub_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned WIDTH         = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [WIDTH-1:0]         dsp_a,
  output logic [WIDTH-1:0]         dsp_b,
  output logic                     dsp_sub,
  input  logic [WIDTH-1:0]         dsp_result,
  output logic                     busy
);

  localparam int unsigned PTR_W      = $clog2(NUM_REQ);
  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_EFF - 1);

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  logic                 op_sub_q, op_sub_d;
  logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [WIDTH-1:0]     sel_a, sel_b;
  logic                 sel_sub;

  dsp_addsub_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (ptr_q),
    .grant_c     (grant),
    .grant_idx_c (grant_idx),
    .grant_any_c (grant_any)
  );

  // Grant is only offered while idle and out of reset.
  assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;

  // Operand mux for the granted requester.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = OP_ADD;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_sub = req_sub[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sub_d    = op_sub_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          op_sub_d = sel_sub;
          owner_d  = grant_idx;
          ptr_d    = PTR_W'(wrap_inc(32'(grant_idx), NUM_REQ));
          cnt_d    = CNT_INIT;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d  = dsp_result;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sub_q    <= OP_ADD;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sub_q    <= op_sub_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign dsp_a     = op_a_q;
  assign dsp_b     = op_b_q;
  assign dsp_sub   = op_sub_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;

endmodule

// File: doc/dsp_addsub_arbiter.md
Name: dsp_addsub_arbiter

Overview:
Shares the single SB_MAC16-based 32-bit add/subtract datapath between NUM_REQ requesters, for example a branch comparator and an address generator. Round-robin arbitration and valid/ready handshakes on both request and response sides. Operands are latched, held stable for SETTLE_CYCLES while the combinational DSP path settles, and the result is captured and returned to the owning requester. Sits beside the DSP unit: drives its operand and ADDSUB controls and reads its output.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
SETTLE_CYCLES, 1, cycles the operands are held before the DSP result is sampled (0 treated as 1)
WIDTH, 32, operand/result width (fixed 32 for the DSP mapping)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  request accepted (one-hot or zero)
req_a  in  WIDTH*NUM_REQ  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  WIDTH*NUM_REQ  operand B, same packing
req_sub  in  NUM_REQ  1 = A-B, 0 = A+B
rsp_valid  out  NUM_REQ  result valid, one-hot to the owner
rsp_ready  in  NUM_REQ  owner accepts result
rsp_data  out  WIDTH  result, shared bus
dsp_a  out  WIDTH  operand A to DSP unit
dsp_b  out  WIDTH  operand B to DSP unit
dsp_sub  out  1  drives ADDSUBTOP/ADDSUBBOT
dsp_result  in  WIDTH  combinational DSP output
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, owner=0, operand regs/dsp_a/dsp_b/dsp_sub/rsp_data=0, rsp_valid=0, req_ready=0, settle counter=0. Deassertion is synchronised externally; the block only requires glitch-free release.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = first asserted req_valid scanning from rr_ptr upward, modulo NUM_REQ.
  - req_ready = grant (combinational from req_valid and rr_ptr; zero outside IDLE).
  - On any grant: latch req_a/req_b/req_sub of the granted requester into operand regs, owner=index, rr_ptr=(index+1) mod NUM_REQ, cnt=SETTLE_CYCLES-1, go EXEC.
  - With no valid request, stay in IDLE with no state change.
- EXEC:
  - dsp_a/dsp_b/dsp_sub come from the operand regs and are stable for the whole state.
  - If cnt==0: rsp_data<=dsp_result, go RESP. Otherwise cnt decrements.
- RESP:
  - rsp_valid[owner]=1 and rsp_data holds until rsp_ready[owner]=1.
  - On handshake, go IDLE and rsp_valid drops next cycle.
  - rsp_ready of non-owners is ignored.
- Latency from the accepting req handshake to rsp_valid is SETTLE_CYCLES+1 cycles. Peak throughput is one operation per SETTLE_CYCLES+2 cycles (no IDLE bypass).
- Arithmetic: modulo 2^32 wrap. No carry, overflow or flags are exported. Add/sub is selected per request and never changes mid-operation.
- Simultaneous requests: the rr_ptr winner is granted and the others wait. A requester must hold valid and operands stable until ready.
- A request from the owner while in RESP is not accepted until IDLE. Withdrawal of a not-yet-granted req_valid is permitted.
- Reset mid-operation: the in-flight operation is dropped, no rsp_valid is issued, and state returns to IDLE.

Decomposition:
- Shared package/defines: state encodings (IDLE=2'd0, EXEC=2'd1, RESP=2'd2) and ADDSUB encoding (OP_ADD=0, OP_SUB=1).
- One sub-module: rr_arbiter (NUM_REQ-wide priority-rotating one-hot grant from req vector and rr_ptr, purely combinational). Keep the FSM, counter and operand regs in the top.

Test Plan:
- Single sub: r0 A=0x00000005, B=0x00000003, sub=1, SETTLE=1 -> req_ready[0] in cycle 0, rsp_valid[0] at cycle 2 with rsp_data=0x00000002; dsp_sub=1 throughout EXEC.
- Wrap: r1 A=0x00000000, B=0x00000001, sub=1 -> 0xFFFFFFFF. r1 A=0xFFFFFFFF, B=0x00000001, sub=0 -> 0x00000000.
- Contention: r0 and r1 both valid continuously with rr_ptr=0 -> grants alternate 0,1,0,1. Each result is routed only to its owner, and no requester waits more than one other operation.
- Backpressure: rsp_ready[0] held low 5 cycles in RESP -> rsp_valid[0] and rsp_data stable, req_ready stays 0 for all requesters, busy=1. Accept on cycle 6 -> IDLE next cycle.
- SETTLE_CYCLES=3: a dsp_result model that changes until cycle 3 after grant -> sampled value is the cycle-3 value, and rsp_valid appears 4 cycles after the handshake.
- Async reset asserted mid-EXEC -> all outputs 0 immediately with no rsp_valid. A fresh request after release is granted to r0 (rr_ptr=0).
